eq_input_framer: RTL and testbench

// Upstream feeder for the 8-band equalizer. Buffers incoming audio samples from a valid/ready

---
 rtl/eq_pkg.sv | 13 +
 rtl/eq_input_framer_sync_fifo.sv | 56 +++++
 rtl/eq_input_framer.sv | 84 ++++++++
 tb/tb_eq_input_framer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared defaults for the equalizer input framer and its sample buffer.
package eq_pkg;

    localparam int DEF_DATA_BITS         = 16;
    localparam int DEF_FRAME_LEN         = 64;
    localparam int DEF_FIFO_DEPTH        = 8;
    localparam int DEF_NUMBER_OF_FILTERS = 8;
    localparam int DEF_GAIN_BITS         = 2;

    localparam int CNT_BITS      = $clog2(DEF_FRAME_LEN);
    localparam int GAIN_VEC_BITS = DEF_NUMBER_OF_FILTERS * DEF_GAIN_BITS;

endpackage

// File: rtl/eq_input_framer_sync_fifo.sv
// Single-clock sample FIFO with first-word fall-through head, occupancy level and async reset.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int LVL_BITS = PTR_BITS + 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                push_ok;
    logic                pop_ok;

    assign full    = (level == LVL_BITS'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/eq_input_framer.sv
// Frames buffered audio samples for the 8-band equalizer: one sample per frame, boundary-aligned
// gain updates, and a clock enable that keeps the equalizer tap counter in step with frame_cnt.
module eq_input_framer
    import eq_pkg::*;
#(
    parameter int DATA_BITS         = DEF_DATA_BITS,
    parameter int FRAME_LEN         = DEF_FRAME_LEN,
    parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
    parameter int NUMBER_OF_FILTERS = DEF_NUMBER_OF_FILTERS,
    parameter int GAIN_BITS         = DEF_GAIN_BITS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   run,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [DATA_BITS-1:0]                   s_data,
    input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] gains_in,
    input  logic                                   gains_wr,
    output logic                                   eq_enable,
    output logic [DATA_BITS-1:0]                   filter_in,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
    output logic [$clog2(FRAME_LEN)-1:0]           frame_cnt,
    output logic                                   frame_start,
    output logic [$clog2(FIFO_DEPTH):0]            fifo_level,
    output logic                                   underrun,
    input  logic                                   underrun_clr
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int GV_W  = NUMBER_OF_FILTERS * GAIN_BITS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [GV_W-1:0]      pending_gains;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 boundary;

    assign boundary    = run && (frame_cnt == LAST);
    assign eq_enable   = run;
    assign frame_start = run && (frame_cnt == '0);
    assign s_ready     = !fifo_full;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .pop   (boundary),
        .din   (s_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt       <= '0;
            filter_in       <= '0;
            amplifier_gains <= '0;
            pending_gains   <= '0;
            underrun        <= 1'b0;
        end else begin
            if (run)
                frame_cnt <= (frame_cnt == LAST) ? '0 : frame_cnt + 1'b1;
            if (gains_wr)
                pending_gains <= gains_in;
            // A gain write on the boundary cycle bypasses the pending register.
            if (boundary) begin
                amplifier_gains <= gains_wr ? gains_in : pending_gains;
                filter_in       <= fifo_empty ? '0 : fifo_head;
            end
            if (boundary && fifo_empty)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eq_input_framer.sv
// Scoreboard bench for eq_input_framer: directed scenarios followed by randomized traffic.
module tb_eq_input_framer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [15:0] gains_in;
    logic        gains_wr;
    logic        eq_enable;
    logic [15:0] filter_in;
    logic [15:0] amplifier_gains;
    logic [5:0]  frame_cnt;
    logic        frame_start;
    logic [3:0]  fifo_level;
    logic        underrun;
    logic        underrun_clr;

    eq_input_framer #(
        .DATA_BITS         (16),
        .FRAME_LEN         (64),
        .FIFO_DEPTH        (8),
        .NUMBER_OF_FILTERS (8),
        .GAIN_BITS         (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .gains_in        (gains_in),
        .gains_wr        (gains_wr),
        .eq_enable       (eq_enable),
        .filter_in       (filter_in),
        .amplifier_gains (amplifier_gains),
        .frame_cnt       (frame_cnt),
        .frame_start     (frame_start),
        .fifo_level      (fifo_level),
        .underrun        (underrun),
        .underrun_clr    (underrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        logic [15:0] filt;
        logic [15:0] gains;
        int          level;
        logic        und;
        logic        rdy;
        logic        en;
        logic        fs;
    } exp_t;

    typedef struct {
        logic [15:0] filt;
        logic [15:0] gains;
    } frm_t;

    exp_t exp_q[$];
    frm_t frm_q[$];

    // Reference model: samples as a plain queue, frame position as an integer.
    logic [15:0] m_q[$];
    int          m_cnt;
    logic [15:0] m_filt;
    logic [15:0] m_gains;
    logic [15:0] m_pend;
    logic        m_und;

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        frm_t f;
        bit   bnd;
        bit   push;
        bit   und_set;
        if (rst) begin
            m_q.delete();
            frm_q.delete();
            m_cnt   = 0;
            m_filt  = '0;
            m_gains = '0;
            m_pend  = '0;
            m_und   = 1'b0;
        end else begin
            bnd     = run && (m_cnt == 63);
            push    = s_valid && (m_q.size() < 8);
            und_set = 1'b0;
            if (bnd) begin
                if (m_q.size() > 0) begin
                    m_filt = m_q.pop_front();
                end else begin
                    m_filt  = '0;
                    und_set = 1'b1;
                end
                m_gains = gains_wr ? gains_in : m_pend;
            end
            if (gains_wr)
                m_pend = gains_in;
            if (push)
                m_q.push_back(s_data);
            if (und_set)
                m_und = 1'b1;
            else if (underrun_clr)
                m_und = 1'b0;
            if (run)
                m_cnt = (m_cnt + 1) % 64;
            if (bnd) begin
                f.filt  = m_filt;
                f.gains = m_gains;
                frm_q.push_back(f);
            end
        end
        e.cnt   = m_cnt;
        e.filt  = m_filt;
        e.gains = m_gains;
        e.level = m_q.size();
        e.und   = m_und;
        e.rdy   = (m_q.size() < 8);
        e.en    = run;
        e.fs    = run && (m_cnt == 0);
        exp_q.push_back(e);
    endtask

    // Inputs are already set; predict the next edge, then wait until the following negedge.
    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic goto(input int target);
        int n = 0;
        while (m_cnt != target && n < 200) begin
            cycle();
            n++;
        end
        chk("goto_reached", 32'(m_cnt), 32'(target));
    endtask

    task automatic clear_pulses();
        s_valid      = 1'b0;
        gains_wr     = 1'b0;
        underrun_clr = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        frm_t f;
        forever begin
            @(posedge clk);
            #1;
            if (done)
                break;
            if (exp_q.size() == 0) begin
                chk("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                chk("filter_in", 32'(filter_in), 32'(e.filt));
                chk("amplifier_gains", 32'(amplifier_gains), 32'(e.gains));
                chk("fifo_level", 32'(fifo_level), 32'(e.level));
                chk("underrun", 32'(underrun), 32'(e.und));
                chk("s_ready", 32'(s_ready), 32'(e.rdy));
                chk("eq_enable", 32'(eq_enable), 32'(e.en));
                chk("frame_start", 32'(frame_start), 32'(e.fs));
            end
            if (frame_start) begin
                if (frm_q.size() == 0) begin
                    chk("frame_record_pending", 32'd0, 32'd1);
                end else begin
                    f = frm_q.pop_front();
                    chk("frame_filter_in", 32'(filter_in), 32'(f.filt));
                    chk("frame_gains", 32'(amplifier_gains), 32'(f.gains));
                end
            end
        end
    end

    initial begin : stimulus
        logic [15:0] held;
        int          rate;

        rst = 1'b1;
        run = 1'b0;
        s_data = '0;
        gains_in = '0;
        clear_pulses();
        cycle();
        cycle();
        chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_fifo_level", 32'(fifo_level), 32'd0);
        chk("reset_filter_in", 32'(filter_in), 32'd0);
        chk("reset_gains", 32'(amplifier_gains), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);

        // First sample reaches filter_in only from frame 1.
        rst = 1'b0;
        run = 1'b1;
        repeat (5) cycle();
        s_valid = 1'b1;
        s_data  = 16'h1234;
        cycle();
        clear_pulses();
        chk("t1_frame0_zero", 32'(filter_in), 32'd0);
        goto(0);
        chk("t1_frame1_sample", 32'(filter_in), 32'h1234);
        goto(63);
        chk("t1_held_to_end", 32'(filter_in), 32'h1234);

        // Empty FIFO at the boundary, then set/clear collision.
        cycle();
        chk("t3_underrun_zero", 32'(filter_in), 32'd0);
        chk("t3_underrun_set", 32'(underrun), 32'd1);
        goto(63);
        underrun_clr = 1'b1;
        cycle();
        chk("t3_set_beats_clr", 32'(underrun), 32'd1);
        cycle();
        chk("t3_clr", 32'(underrun), 32'd0);
        clear_pulses();

        // Fill to capacity; extra valid is ignored.
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 16'h0100 + 16'(i);
            cycle();
        end
        chk("t2_level_full", 32'(fifo_level), 32'd8);
        chk("t2_not_ready", 32'(s_ready), 32'd0);
        s_data = 16'hDEAD;
        cycle();
        chk("t2_ninth_ignored", 32'(fifo_level), 32'd8);
        goto(0);
        clear_pulses();
        chk("t2_pop_level", 32'(fifo_level), 32'd7);
        chk("t2_ready_back", 32'(s_ready), 32'd1);
        chk("t2_head_value", 32'(filter_in), 32'h0100);

        // Gain shadowing and boundary write-through.
        goto(10);
        gains_wr = 1'b1;
        gains_in = 16'hAAAA;
        cycle();
        clear_pulses();
        chk("t4_gains_shadowed", 32'(amplifier_gains), 32'd0);
        goto(0);
        chk("t4_gains_applied", 32'(amplifier_gains), 32'hAAAA);
        goto(63);
        gains_wr = 1'b1;
        gains_in = 16'h5555;
        cycle();
        clear_pulses();
        chk("t4_write_through", 32'(amplifier_gains), 32'h5555);

        // Pause mid-frame.
        goto(30);
        run  = 1'b0;
        held = filter_in;
        repeat (20) cycle();
        chk("t5_eq_enable_low", 32'(eq_enable), 32'd0);
        chk("t5_cnt_held", 32'(frame_cnt), 32'd30);
        chk("t5_filter_held", 32'(filter_in), 32'(held));
        run = 1'b1;
        cycle();
        chk("t5_resume", 32'(frame_cnt), 32'd31);

        // Reset mid-frame with samples queued.
        rst = 1'b1;
        run = 1'b0;
        cycle();
        rst = 1'b0;
        run = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 16'h0A00 + 16'(i);
            cycle();
        end
        clear_pulses();
        goto(20);
        chk("t6_three_queued", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        run = 1'b0;
        cycle();
        chk("t6_level_cleared", 32'(fifo_level), 32'd0);
        chk("t6_cnt_cleared", 32'(frame_cnt), 32'd0);
        chk("t6_filter_cleared", 32'(filter_in), 32'd0);
        rst = 1'b0;
        cycle();
        chk("t6_ready_after", 32'(s_ready), 32'd1);
        run = 1'b1;

        // Randomized traffic: sample rate varies so the FIFO both fills and starves.
        rate = 40;
        for (int i = 0; i < 2500; i++) begin
            if (i % 256 == 0) begin
                case ($urandom_range(0, 3))
                    0:       rate = 20;
                    1:       rate = 40;
                    2:       rate = 80;
                    default: rate = 160;
                endcase
            end
            rst          = ($urandom_range(0, 799) == 0);
            run          = rst ? 1'b0 : ($urandom_range(0, 9) != 0);
            s_valid      = ($urandom_range(0, rate - 1) < 2);
            s_data       = 16'($urandom());
            gains_wr     = ($urandom_range(0, 49) == 0);
            gains_in     = 16'($urandom());
            underrun_clr = ($urandom_range(0, 29) == 0);
            cycle();
        end

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
